// File: rtl/key_defs.sv
// Shared key definitions: FSM state encodings and the pressed key level.
package key_defs;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRESS  = 3'd1,
        ST_HOLD   = 3'd2,
        ST_WAIT   = 3'd3,
        ST_SECOND = 3'd4
    } key_state_e;

    // Debounced level that means "key is held down".
    localparam logic KEY_PRESSED = 1'b0;

endpackage

// File: rtl/key_event_timer.sv
// Gesture timer: up counter with synchronous clear/enable and terminal matches
// for the long-press hold time and the double-click release gap.
module key_event_timer #(
    parameter int unsigned LONG_CNT   = 50_000_000,
    parameter int unsigned DCLICK_CNT = 15_000_000,
    parameter int unsigned CNT_W      = 26
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_long_hit,
    output logic o_dclick_hit
);

    localparam logic [CNT_W-1:0] LONG_TERM   = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] DCLICK_TERM = CNT_W'(DCLICK_CNT - 1);

    logic [CNT_W-1:0] r_cnt;

    // Count while enabled; clear has priority; hold at all-ones rather than wrap.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_long_hit   = (r_cnt == LONG_TERM);
    assign o_dclick_hit = (r_cnt == DCLICK_TERM);

endmodule

// File: rtl/key_event_decoder.sv
// Key gesture classifier: turns debounced press/release strobes into one-cycle
// short_press / long_press / double_click pulses.
// Optional double-click support: define KEY_EVENT_DOUBLE_CLICK_EN.
module key_event_decoder
    import key_defs::*;
#(
    parameter int unsigned LONG_CNT   = 50_000_000,
    parameter int unsigned DCLICK_CNT = 15_000_000,
    parameter int unsigned CNT_W      = 26
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic keyvalue,
    input  logic keyflag,
    output logic short_press,
    output logic long_press,
    output logic double_click,
    output logic key_busy
);

    key_state_e r_state;
    key_state_e w_state_n;
    logic       w_press_ev;
    logic       w_release_ev;
    logic       w_long_hit;
    logic       w_dclick_hit;
    logic       w_cnt_clr;
    logic       w_cnt_en;
    logic       w_short;
    logic       w_long;
    logic       r_short;
    logic       r_long;
`ifdef KEY_EVENT_DOUBLE_CLICK_EN
    logic       w_dclick;
    logic       r_dclick;
`else
    logic       w_unused_dclick_hit;
    assign w_unused_dclick_hit = w_dclick_hit;
`endif

    assign w_press_ev   = keyflag && (keyvalue == KEY_PRESSED);
    assign w_release_ev = keyflag && (keyvalue != KEY_PRESSED);

    // Timer restarts on every state change so each state times itself from entry.
    assign w_cnt_clr = (w_state_n != r_state);
`ifdef KEY_EVENT_DOUBLE_CLICK_EN
    assign w_cnt_en = (r_state == ST_PRESS) || (r_state == ST_WAIT) || (r_state == ST_SECOND);
`else
    assign w_cnt_en = (r_state == ST_PRESS);
`endif

    key_event_timer #(
        .LONG_CNT   (LONG_CNT),
        .DCLICK_CNT (DCLICK_CNT),
        .CNT_W      (CNT_W)
    ) u_timer (
        .i_clk        (sys_clk),
        .i_rst_n      (sys_rst_n),
        .i_clr        (w_cnt_clr),
        .i_en         (w_cnt_en),
        .o_long_hit   (w_long_hit),
        .o_dclick_hit (w_dclick_hit)
    );

    // Next-state and pulse decode; key events take priority over timer terminals.
    always_comb begin
        w_state_n = r_state;
        w_short   = 1'b0;
        w_long    = 1'b0;
`ifdef KEY_EVENT_DOUBLE_CLICK_EN
        w_dclick  = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_press_ev) w_state_n = ST_PRESS;
            end
            ST_PRESS: begin
                if (w_release_ev) begin
`ifdef KEY_EVENT_DOUBLE_CLICK_EN
                    w_state_n = ST_WAIT;
`else
                    w_short   = 1'b1;
                    w_state_n = ST_IDLE;
`endif
                end else if (w_long_hit) begin
                    w_long    = 1'b1;
                    w_state_n = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_release_ev) w_state_n = ST_IDLE;
            end
`ifdef KEY_EVENT_DOUBLE_CLICK_EN
            ST_WAIT: begin
                if (w_press_ev) begin
                    w_state_n = ST_SECOND;
                end else if (w_dclick_hit) begin
                    w_short   = 1'b1;
                    w_state_n = ST_IDLE;
                end
            end
            ST_SECOND: begin
                if (w_release_ev) begin
                    w_dclick  = 1'b1;
                    w_state_n = ST_IDLE;
                end else if (w_long_hit) begin
                    w_long    = 1'b1;
                    w_state_n = ST_HOLD;
                end
            end
`endif
            default: w_state_n = ST_IDLE;
        endcase
    end

    // State register and registered event pulses.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= ST_IDLE;
            r_short <= 1'b0;
            r_long  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_short <= w_short;
            r_long  <= w_long;
        end
    end

`ifdef KEY_EVENT_DOUBLE_CLICK_EN
    // Registered double-click pulse.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) r_dclick <= 1'b0;
        else            r_dclick <= w_dclick;
    end
    assign double_click = r_dclick;
`else
    assign double_click = 1'b0;
`endif

    assign short_press = r_short;
    assign long_press  = r_long;
    assign key_busy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_key_event_decoder.sv
// Testbench for key_event_decoder: gesture-level reference model, random and
// boundary gestures, reset checks. Honours KEY_EVENT_DOUBLE_CLICK_EN.
module tb_key_event_decoder;

    localparam int L    = 10;
    localparam int DC   = 6;
    localparam int MAXC = 4096;
`ifdef KEY_EVENT_DOUBLE_CLICK_EN
    localparam bit DC_EN = 1'b1;
`else
    localparam bit DC_EN = 1'b0;
`endif

    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    logic keyvalue = 1'b1;
    logic keyflag = 1'b0;
    logic short_press, long_press, double_click, key_busy;

    int n_total = 0;
    int n_bad   = 0;

    int ev_t[$];
    int cur;
    int n_cyc;
    bit st_flag[MAXC];
    bit st_val[MAXC];
    bit ex_s[MAXC];
    bit ex_l[MAXC];
    bit ex_d[MAXC];
    bit ex_b[MAXC];

    key_event_decoder #(
        .LONG_CNT   (L),
        .DCLICK_CNT (DC),
        .CNT_W      (8)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .keyvalue     (keyvalue),
        .keyflag      (keyflag),
        .short_press  (short_press),
        .long_press   (long_press),
        .double_click (double_click),
        .key_busy     (key_busy)
    );

    always #10 sys_clk = ~sys_clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic check_quiet(input string tag, input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            @(posedge sys_clk);
            #1;
            check_val($sformatf("%s_short@%0d", tag, c), short_press, 0);
            check_val($sformatf("%s_long@%0d", tag, c), long_press, 0);
            check_val($sformatf("%s_dclick@%0d", tag, c), double_click, 0);
            check_val($sformatf("%s_busy@%0d", tag, c), key_busy, 0);
        end
    endtask

    // One gesture: press d1 cycles; optional second press after gap for d2 cycles.
    task automatic add_gesture(input int d1, input int gap, input int d2, input int tail);
        ev_t.push_back(cur);
        cur += d1;
        ev_t.push_back(cur);
        if (d2 > 0) begin
            cur += gap;
            ev_t.push_back(cur);
            cur += d2;
            ev_t.push_back(cur);
        end
        cur += tail;
    endtask

    task automatic build_and_model();
        int  k;
        int  i;
        int  n;
        int  p, r, q, s, fin;
        bit  level;
        n_cyc = cur + L + DC + 10;
        level = 1'b1;
        k = 0;
        for (int t = 0; t < n_cyc; t++) begin
            ex_s[t] = 0; ex_l[t] = 0; ex_d[t] = 0; ex_b[t] = 0;
            if (k < ev_t.size() && ev_t[k] == t) begin
                level      = (k % 2 == 0) ? 1'b0 : 1'b1;
                st_flag[t] = 1'b1;
                st_val[t]  = level;
                k++;
            end else begin
                st_flag[t] = 1'b0;
                st_val[t]  = ($urandom_range(0, 7) == 0) ? ~level : level;
            end
        end
        // Gesture-level expectations from press/release times.
        n = ev_t.size();
        i = 0;
        while (i < n) begin
            p = ev_t[i];
            r = ev_t[i+1];
            if (r - p > L) begin
                ex_l[p+L] = 1; fin = r; i += 2;
            end else if (!DC_EN) begin
                ex_s[r] = 1; fin = r; i += 2;
            end else if (i + 2 < n && ev_t[i+2] - r <= DC) begin
                q = ev_t[i+2];
                s = ev_t[i+3];
                if (s - q > L) ex_l[q+L] = 1;
                else           ex_d[s] = 1;
                fin = s; i += 4;
            end else begin
                ex_s[r+DC] = 1; fin = r + DC; i += 2;
            end
            for (int t = p; t < fin; t++) ex_b[t] = 1;
        end
    endtask

    task automatic run_sequence();
        for (int t = 0; t < n_cyc; t++) begin
            @(negedge sys_clk);
            keyflag  = st_flag[t];
            keyvalue = st_val[t];
            @(posedge sys_clk);
            #1;
            check_val($sformatf("short@%0d", t), short_press, ex_s[t]);
            check_val($sformatf("long@%0d", t), long_press, ex_l[t]);
            check_val($sformatf("dclick@%0d", t), double_click, ex_d[t]);
            check_val($sformatf("busy@%0d", t), key_busy, ex_b[t]);
        end
        @(negedge sys_clk);
        keyflag  = 1'b0;
        keyvalue = 1'b1;
    endtask

    task automatic key_event(input bit v);
        @(negedge sys_clk);
        keyflag  = 1'b1;
        keyvalue = v;
        @(negedge sys_clk);
        keyflag  = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state and idle quiet period.
        repeat (3) @(posedge sys_clk);
        #1;
        check_val("rst_short", short_press, 0);
        check_val("rst_long", long_press, 0);
        check_val("rst_dclick", double_click, 0);
        check_val("rst_busy", key_busy, 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        check_quiet("idle", 20);

        // Directed gestures, then random ones.
        cur = 2;
        add_gesture(4, 0, 0, 12);   // short press
        add_gesture(15, 0, 0, 12);  // long press, held past terminal
        add_gesture(3, 3, 3, 12);   // double click
        add_gesture(10, 0, 0, 12);  // release on the long terminal cycle
        add_gesture(3, 6, 2, 12);   // second press on the gap terminal cycle
        add_gesture(2, 7, 3, 12);   // second press just too late
        add_gesture(2, 2, 12, 12);  // second press held long
        add_gesture(2, 2, 10, 12);  // second release on the long terminal cycle
        add_gesture(11, 0, 0, 12);  // release one cycle after long
        while (cur < MAXC - 200) begin
            if ($urandom_range(0, 1) == 0)
                add_gesture($urandom_range(1, 14), 0, 0, $urandom_range(1, 10));
            else
                add_gesture($urandom_range(1, 14), $urandom_range(1, 8),
                            $urandom_range(1, 13), $urandom_range(1, 10));
        end
        build_and_model();
        run_sequence();

        // Reset during HOLD: outputs drop at once, nothing afterwards.
        key_event(1'b0);
        repeat (12) @(negedge sys_clk);
        check_val("hold_busy_pre", key_busy, 1);
        #5 sys_rst_n = 1'b0;
        #1;
        check_val("hold_rst_busy", key_busy, 0);
        check_val("hold_rst_long", long_press, 0);
        key_event(1'b1);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        check_quiet("hold_after", 20);

        // Reset during the release gap of a would-be short press.
        key_event(1'b0);
        repeat (2) @(negedge sys_clk);
        key_event(1'b1);
        @(negedge sys_clk);
        check_val("wait_busy_pre", key_busy, DC_EN);
        #5 sys_rst_n = 1'b0;
        #1;
        check_val("wait_rst_busy", key_busy, 0);
        check_val("wait_rst_short", short_press, 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        check_quiet("wait_after", 20);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
